id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Each edge applies hold, bubble or load; bubble_cnt counts inserted bubbles.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_RegWrite,
    input  logic        id_MemToReg,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_ALUSrc,
    input  logic        id_RegDst,
    input  logic [1:0]  id_ALUOp,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_Rs,
    input  logic [4:0]  id_Rt,
    input  logic [4:0]  id_Rd,
    input  logic        id_uses_rt,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        ID_EX_valid,
    output logic        ID_EX_RegWrite,
    output logic        ID_EX_MemToReg,
    output logic        ID_EX_MemRead,
    output logic        ID_EX_MemWrite,
    output logic        ID_EX_ALUSrc,
    output logic        ID_EX_RegDst,
    output logic [1:0]  ID_EX_ALUOp,
    output logic [31:0] ID_EX_rs_data,
    output logic [31:0] ID_EX_rt_data,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_Rs,
    output logic [4:0]  ID_EX_Rt,
    output logic [4:0]  ID_EX_Rd,
    output logic        hazard_stall,
    output logic [15:0] bubble_cnt
);

    logic        valid_q,     valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        alu_src_q,   alu_src_d;
    logic        reg_dst_q,   reg_dst_d;
    logic [1:0]  alu_op_q,    alu_op_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm_q,       imm_d;
    logic [4:0]  rs_q,        rs_d;
    logic [4:0]  rt_q,        rt_d;
    logic [4:0]  rd_q,        rd_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Load-use: the load in EX writes a register the ID instruction reads; $zero never hazards.
    assign hazard_stall = valid_q & mem_read_q & (rt_q != 5'd0) & id_valid &
                          ((rt_q == id_Rs) | (id_uses_rt & (rt_q == id_Rt)));

    // Next-state selection: hold, bubble, or load, in that priority.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        alu_op_d     = alu_op_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ext_stall) begin
            bubble_cnt_d = bubble_cnt_q;
        end else if (flush || hazard_stall) begin
            // Specifiers and data are cleared too so a bubble never matches a forwarding compare.
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            reg_dst_d    = 1'b0;
            alu_op_d     = 2'b00;
            rs_data_d    = 32'd0;
            rt_data_d    = 32'd0;
            imm_d        = 32'd0;
            rs_d         = 5'd0;
            rt_d         = 5'd0;
            rd_d         = 5'd0;
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else begin
            valid_d      = id_valid;
            reg_write_d  = id_RegWrite & id_valid;
            mem_to_reg_d = id_MemToReg & id_valid;
            mem_read_d   = id_MemRead  & id_valid;
            mem_write_d  = id_MemWrite & id_valid;
            alu_src_d    = id_ALUSrc   & id_valid;
            reg_dst_d    = id_RegDst   & id_valid;
            alu_op_d     = id_ALUOp & {2{id_valid}};
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            imm_d        = id_imm;
            rs_d         = id_Rs;
            rt_d         = id_Rt;
            rd_d         = id_Rd;
        end
    end

    // Pipeline register state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            alu_op_q     <= alu_op_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ID_EX_valid    = valid_q;
    assign ID_EX_RegWrite = reg_write_q;
    assign ID_EX_MemToReg = mem_to_reg_q;
    assign ID_EX_MemRead  = mem_read_q;
    assign ID_EX_MemWrite = mem_write_q;
    assign ID_EX_ALUSrc   = alu_src_q;
    assign ID_EX_RegDst   = reg_dst_q;
    assign ID_EX_ALUOp    = alu_op_q;
    assign ID_EX_rs_data  = rs_data_q;
    assign ID_EX_rt_data  = rt_data_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_Rs       = rs_q;
    assign ID_EX_Rt       = rt_q;
    assign ID_EX_Rd       = rd_q;
    assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage plus hand sequences for reset-in-stall,
// counter saturation and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegDst;
    logic [1:0]  id_ALUOp;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_Rs, id_Rt, id_Rd;
    logic        id_uses_rt, flush, ext_stall;
    logic        ID_EX_valid, ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_RegDst;
    logic [1:0]  ID_EX_ALUOp;
    logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm;
    logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
    logic        hazard_stall;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
        .id_ALUOp(id_ALUOp), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd), .id_uses_rt(id_uses_rt), .flush(flush),
        .ext_stall(ext_stall), .ID_EX_valid(ID_EX_valid), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_rs_data(ID_EX_rs_data), .ID_EX_rt_data(ID_EX_rt_data), .ID_EX_imm(ID_EX_imm),
        .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    // ctrl packing: {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
    wire [119:0] st = {ID_EX_valid, ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_MemRead, ID_EX_MemWrite,
                       ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp, ID_EX_rs_data, ID_EX_rt_data,
                       ID_EX_imm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd};

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, rd;
        logic        ur, fl, ex;
        logic        hz;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic [31:0] e_rs_d, e_rt_d, e_imm;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [15:0] e_bc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(
        input logic valid, input logic [7:0] ctrl, input logic [31:0] rs_d, input logic [31:0] rt_d,
        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic ur, input logic fl, input logic ex, input logic hz, input logic e_valid,
        input logic [7:0] e_ctrl, input logic [31:0] e_rs_d, input logic [31:0] e_rt_d,
        input logic [31:0] e_imm, input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [4:0] e_rd,
        input logic [15:0] e_bc);
        vec_t v;
        v.valid = valid; v.ctrl = ctrl; v.rs_d = rs_d; v.rt_d = rt_d; v.imm = imm;
        v.rs = rs; v.rt = rt; v.rd = rd; v.ur = ur; v.fl = fl; v.ex = ex; v.hz = hz;
        v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.e_rs_d = e_rs_d; v.e_rt_d = e_rt_d; v.e_imm = e_imm;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_rd = e_rd; v.e_bc = e_bc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid;
        {id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegDst, id_ALUOp} = v.ctrl;
        id_rs_data = v.rs_d; id_rt_data = v.rt_d; id_imm = v.imm;
        id_Rs = v.rs; id_Rt = v.rt; id_Rd = v.rd;
        id_uses_rt = v.ur; flush = v.fl; ext_stall = v.ex;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [119:0] exp_st(input vec_t v);
        return {v.e_valid, v.e_ctrl, v.e_rs_d, v.e_rt_d, v.e_imm, v.e_rs, v.e_rt, v.e_rd};
    endfunction

    vec_t idle, lw8, use8, add1;

    initial begin
        //                 val ctrl   rs_d          rt_d     imm           Rs Rt Rd ur fl ex | hz ev ectrl e_rs_d       e_rt_d   e_imm          eRs eRt eRd bc
        tbl[0]  = mk(1'b1, 8'h80, 32'h1234,     32'h0,   32'h0,        5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 32'h1234, 32'h0, 32'h0, 5'd3, 5'd4, 5'd5, 16'd0);
        tbl[1]  = mk(1'b1, 8'hE8, 32'h100,      32'h0,   32'h10,       5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE8, 32'h100, 32'h0, 32'h10, 5'd2, 5'd8, 5'd0, 16'd0);
        tbl[2]  = mk(1'b1, 8'h86, 32'hAAAA,     32'hBBBB, 32'h0,       5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd1);
        tbl[3]  = mk(1'b1, 8'h86, 32'hAAAA,     32'hBBBB, 32'h0,       5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h86, 32'hAAAA, 32'hBBBB, 32'h0, 5'd8, 5'd9, 5'd10, 16'd1);
        tbl[4]  = mk(1'b1, 8'hE8, 32'h200,      32'h0,   32'h4,        5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE8, 32'h200, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 16'd1);
        tbl[5]  = mk(1'b1, 8'hE8, 32'h300,      32'h0,   32'h8,        5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE8, 32'h300, 32'h0, 32'h8, 5'd0, 5'd9, 5'd0, 16'd1);
        tbl[6]  = mk(1'b1, 8'h86, 32'h1,        32'h2,   32'h0,        5'd1, 5'd9, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE8, 32'h300, 32'h0, 32'h8, 5'd0, 5'd9, 5'd0, 16'd1);
        tbl[7]  = mk(1'b1, 8'h86, 32'h1,        32'h2,   32'h0,        5'd1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hE8, 32'h300, 32'h0, 32'h8, 5'd0, 5'd9, 5'd0, 16'd1);
        tbl[8]  = mk(1'b1, 8'h86, 32'h1,        32'h2,   32'h0,        5'd1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd2);
        tbl[9]  = mk(1'b0, 8'hFF, 32'hDEADBEEF, 32'h5,   32'hFFFFFFF0, 5'd7, 5'd6, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'hDEADBEEF, 32'h5, 32'hFFFFFFF0, 5'd7, 5'd6, 5'd31, 16'd2);
        tbl[10] = mk(1'b1, 8'h20, 32'h0,        32'h0,   32'h0,        5'd6, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 32'h0, 32'h0, 32'h0, 5'd6, 5'd12, 5'd0, 16'd2);
        tbl[11] = mk(1'b1, 8'h86, 32'h1,        32'h2,   32'h0,        5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd3);

        idle = mk(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd0);
        lw8  = tbl[1];
        use8 = tbl[2];
        use8.ex = 1'b1;
        add1 = tbl[0];

        rst = 1'b1;
        drive(idle);
        #2;
        check("reset_state", {8'd0, st}, 128'd0);
        check("reset_bcnt", {112'd0, bubble_cnt}, 128'd0);
        check("reset_hz", {127'd0, hazard_stall}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            #2;
            check($sformatf("vec%0d_hz", i), {127'd0, hazard_stall}, {127'd0, tbl[i].hz});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), {8'd0, st}, {8'd0, exp_st(tbl[i])});
            check($sformatf("vec%0d_bcnt", i), {112'd0, bubble_cnt}, {112'd0, tbl[i].e_bc});
        end

        // Reset while a load-use is held by ext_stall discards the held load.
        drive(lw8);
        @(posedge clk);
        #1;
        drive(use8);
        #2;
        check("held_hz", {127'd0, hazard_stall}, 128'd1);
        @(posedge clk);
        #1;
        check("held_state", {8'd0, st}, {8'd0, exp_st(lw8)});
        check("held_hz_after_edge", {127'd0, hazard_stall}, 128'd1);
        rst = 1'b1;
        #1;
        check("rst_midstall_state", {8'd0, st}, 128'd0);
        check("rst_midstall_bcnt", {112'd0, bubble_cnt}, 128'd0);
        check("rst_midstall_hz", {127'd0, hazard_stall}, 128'd0);
        #2;
        rst = 1'b0;
        drive(add1);
        @(posedge clk);
        #1;
        check("first_edge_after_rst", {8'd0, st}, {8'd0, exp_st(add1)});

        // Saturation: 65534 bubbles, then two more that must stop at 16'hFFFF.
        drive(idle);
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("bcnt_fffe", {112'd0, bubble_cnt}, {112'd0, 16'hFFFE});
        @(posedge clk);
        #1;
        check("bcnt_ffff", {112'd0, bubble_cnt}, {112'd0, 16'hFFFF});
        @(posedge clk);
        #1;
        check("bcnt_saturated", {112'd0, bubble_cnt}, {112'd0, 16'hFFFF});
        flush = 1'b0;
        drive(add1);
        @(posedge clk);
        #1;
        check("load_after_sat", {8'd0, st}, {8'd0, exp_st(add1)});
        rst = 1'b1;
        #1;
        check("async_rst_state", {8'd0, st}, 128'd0);
        check("async_rst_bcnt", {112'd0, bubble_cnt}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
